// File: rtl/npu_acc_pkg.sv
// Shared definitions for the NPU partial-sum accumulation stage:
// FSM state encoding and parameter-legality helpers.
package npu_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  // The accumulator must hold 2^cnt_w terms of in_w bits without wrapping.
  function automatic bit acc_width_ok(input int unsigned in_w, input int unsigned cnt_w,
                                      input int unsigned acc_w);
    return acc_w >= in_w + cnt_w;
  endfunction

  function automatic bit out_width_ok(input int unsigned out_w, input int unsigned acc_w);
    return (out_w >= 1) && (out_w <= acc_w);
  endfunction

endpackage

// File: rtl/signed_saturate.sv
// Combinational signed narrowing: clamps (or truncates) an IN_WIDTH value to
// OUT_WIDTH and flags when clamping took place.
module signed_saturate #(
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic [IN_WIDTH-1:0]  value_i,
  output logic [OUT_WIDTH-1:0] value_o,
  output logic                 overflow_o
);

  localparam int unsigned HI_W = IN_WIDTH - OUT_WIDTH + 1;

  logic [HI_W-1:0] hi;
  logic            fits;

  // The value fits when every bit from the output sign bit upward matches.
  assign hi   = value_i[IN_WIDTH-1:OUT_WIDTH-1];
  assign fits = (hi == '0) || (hi == '1);

  always_comb begin
    value_o    = value_i[OUT_WIDTH-1:0];
    overflow_o = 1'b0;
    if (SATURATE && !fits) begin
      overflow_o = 1'b1;
      value_o    = value_i[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Streaming signed partial-sum accumulator: sums cfg_len terms per group and
// emits one saturated (or truncated) result per group with a one-entry hold.
module psum_accumulator
  import npu_acc_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned OUT_WIDTH = 16,
  parameter string       SATURATE  = "TRUE"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_overflow
);

  if (!acc_width_ok(IN_WIDTH, CNT_WIDTH, ACC_WIDTH)) begin : g_bad_acc_width
    $error("psum_accumulator: ACC_WIDTH must be >= IN_WIDTH + CNT_WIDTH");
  end
  if (!out_width_ok(OUT_WIDTH, ACC_WIDTH)) begin : g_bad_out_width
    $error("psum_accumulator: OUT_WIDTH must be <= ACC_WIDTH");
  end

  localparam bit SAT_EN = (SATURATE == "TRUE");

  acc_state_e                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, term;
  logic [CNT_WIDTH-1:0]        remain_q, remain_d;
  logic [OUT_WIDTH-1:0]        out_data_q, out_data_d, sat_data;
  logic                        out_ovf_q, out_ovf_d, sat_ovf;
  logic                        beat, first, last;

  assign term = ACC_WIDTH'(signed'(in_data));

  signed_saturate #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SATURATE (SAT_EN)
  ) u_sat (
    .value_i   (acc_d),
    .value_o   (sat_data),
    .overflow_o(sat_ovf)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    remain_d   = remain_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    first      = 1'b0;
    last       = 1'b0;
    beat       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = enable;
        first    = 1'b1;
      end
      ST_ACCUM: begin
        in_ready = enable;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = enable & out_ready;
        first     = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready = in_ready & reset;
    beat     = in_valid & in_ready;

    // A beat taken in HOLD implies the handshake, so it opens the next group.
    if (beat) begin
      if (first) begin
        acc_d    = term;
        remain_d = cfg_len - 1'b1;
        last     = (cfg_len == CNT_WIDTH'(1));
      end else begin
        acc_d    = acc_q + term;
        remain_d = remain_q - 1'b1;
        last     = (remain_q == CNT_WIDTH'(1));
      end
      state_d = last ? ST_HOLD : ST_ACCUM;
      if (last) begin
        out_data_d = sat_data;
        out_ovf_d  = sat_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      remain_q   <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      remain_q   <= remain_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a group-level model checks both a
// saturating and a truncating instance every cycle, plus literal spot checks.
module tb_psum_accumulator;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned OUT_W = 16;
  localparam int          OMAX  = (1 << (OUT_W - 1)) - 1;
  localparam int          OMIN  = -(1 << (OUT_W - 1));

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [IN_W-1:0]  in_data = '0;

  logic             in_ready, out_valid, out_overflow;
  logic [OUT_W-1:0] out_data;
  logic             t_in_ready, t_out_valid, t_out_overflow;
  logic [OUT_W-1:0] t_out_data;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  psum_accumulator #(
    .IN_WIDTH(IN_W), .CNT_WIDTH(CNT_W), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W), .SATURATE("TRUE")
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow)
  );

  psum_accumulator #(
    .IN_WIDTH(IN_W), .CNT_WIDTH(CNT_W), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W), .SATURATE("FALSE")
  ) dut_trunc (
    .clk(clk), .reset(reset), .enable(enable), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
    .out_overflow(t_out_overflow)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Group-level model: collects accepted terms, forms group sums, and queues results.
  int     q_sat[$];
  int     q_ovf[$];
  int     q_trn[$];
  int     grp_len = 0;
  int     grp_cnt = 0;
  longint grp_sum = 0;
  bit     exp_valid = 1'b0;

  always @(negedge clk) begin
    bit               exp_rdy, last;
    logic [OUT_W-1:0] tv;
    if (!reset) begin
      q_sat.delete(); q_ovf.delete(); q_trn.delete();
      grp_cnt   = 0;
      grp_sum   = 0;
      exp_valid = 1'b0;
      chk("m_rst_in_ready", in_ready, 0);
      chk("m_rst_out_valid", out_valid, 0);
      chk("m_rst_out_data", out_data, 0);
    end else begin
      exp_rdy = enable && (!exp_valid || out_ready);
      chk("m_in_ready", in_ready, exp_rdy);
      chk("m_out_valid", out_valid, exp_valid);
      chk("m_t_in_ready", t_in_ready, exp_rdy);
      chk("m_t_out_valid", t_out_valid, exp_valid);
      if (exp_valid && q_sat.size() > 0) begin
        chk("m_out_data", $signed(out_data), q_sat[0]);
        chk("m_out_overflow", out_overflow, q_ovf[0]);
        chk("m_t_out_data", $signed(t_out_data), q_trn[0]);
        chk("m_t_out_overflow", t_out_overflow, 0);
        if (out_ready) begin
          void'(q_sat.pop_front()); void'(q_ovf.pop_front()); void'(q_trn.pop_front());
        end
      end
      last = 1'b0;
      if (in_valid && exp_rdy) begin
        if (grp_cnt == 0) begin
          grp_len = (cfg_len == 0) ? (1 << CNT_W) : int'(cfg_len);
          grp_sum = 0;
        end
        grp_sum += longint'($signed(in_data));
        grp_cnt++;
        if (grp_cnt == grp_len) begin
          if (grp_sum > OMAX)      begin q_sat.push_back(OMAX); q_ovf.push_back(1); end
          else if (grp_sum < OMIN) begin q_sat.push_back(OMIN); q_ovf.push_back(1); end
          else                     begin q_sat.push_back(int'(grp_sum)); q_ovf.push_back(0); end
          tv = grp_sum[OUT_W-1:0];
          q_trn.push_back(int'($signed(tv)));
          grp_cnt = 0;
          last    = 1'b1;
        end
      end
      exp_valid = last || (exp_valid && !out_ready);
    end
  end

  task automatic beat(input int v);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input int d, input int o, input int t,
                               input int unsigned budget);
    int unsigned n = 0;
    @(negedge clk);
    while (!out_valid && n < budget) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, $signed(out_data), d);
    chk({name, "_ovf"}, out_overflow, o);
    chk({name, "_trunc"}, $signed(t_out_data), t);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t0;
    enable = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_overflow, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Basic group
    cfg_len = 4;
    for (int i = 1; i <= 4; i++) beat(i);
    expect_result("basic", 10, 0, 10, 0);

    // Saturation both directions
    cfg_len = 3;
    repeat (3) beat(30000);
    expect_result("sat_pos", 32767, 1, 24464, 0);
    repeat (3) beat(-30000);
    expect_result("sat_neg", -32768, 1, -24464, 0);

    // Back-to-back groups without bubbles
    cfg_len = 2;
    t0 = cyc;
    beat(1); beat(2); beat(3); beat(4);
    chk("throughput_cycles", longint'(cyc - t0), 4);
    expect_result("tp_second", 7, 0, 7, 0);

    // Full-length group; cfg_len changes mid-group must be ignored
    cfg_len = 0;
    beat(-32768);
    cfg_len = 7;
    repeat (254) beat(-32768);
    @(negedge clk);
    chk("full_not_done", out_valid, 0);
    @(posedge clk); #1;
    beat(-32768);
    expect_result("full", -32768, 1, 0, 0);
    cfg_len = 1;
    beat(5);
    expect_result("after_full", 5, 0, 5, 0);

    // Backpressure then same-cycle hand-over
    cfg_len = 2; out_ready = 1'b0;
    beat(5); beat(6);
    in_valid = 1'b1; in_data = 7; cfg_len = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", $signed(out_data), 11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("handover_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_result("handover", 7, 0, 7, 0);

    // HOLD drains with enable low
    cfg_len = 1;
    beat(9);
    enable = 1'b0;
    @(negedge clk);
    chk("drain_valid", out_valid, 1);
    chk("drain_data", $signed(out_data), 9);
    chk("drain_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_done", out_valid, 0);
    @(posedge clk); #1;
    enable = 1'b1;

    // Enable stall mid-group
    cfg_len = 3;
    beat(10); beat(20);
    enable = 1'b0; in_valid = 1'b1; in_data = 30;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_result("stall", 60, 0, 60, 0);

    // Reset mid-group discards the partial sum
    cfg_len = 4;
    beat(100); beat(100);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_ovf", out_overflow, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) beat(1);
    expect_result("post_reset", 4, 0, 4, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Streaming signed partial-sum accumulator that sits directly downstream of the NPU signed adder stage. It consumes one signed sum per cycle over a valid/ready handshake and accumulates a group of `cfg_len` terms in a wide internal register. It then emits one saturated result per group over a valid/ready output with a single-entry output hold. Back-to-back groups sustain one input beat per cycle.

## Interface
- `IN_WIDTH`, default 16: width of the signed input term (matches the adder `OUT_WIDTH`).
- `CNT_WIDTH`, default 8: width of `cfg_len`; a group holds at most 2^CNT_WIDTH terms.
- `ACC_WIDTH`, default 24: internal accumulator width; must be ≥ IN_WIDTH+CNT_WIDTH (elaboration error otherwise).
- `OUT_WIDTH`, default 16: width of the signed result; must be ≤ ACC_WIDTH.
- `SATURATE`, default "TRUE": "TRUE" clamps to the OUT_WIDTH range; "FALSE" truncates to the low OUT_WIDTH bits.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: input-side stall; when 0, no input beat is accepted and the accumulator and counter hold.
- `cfg_len`, in, CNT_WIDTH: terms per group, sampled on the first beat of each group; 0 means 2^CNT_WIDTH.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block accepts a beat this cycle.
- `in_data`, in, IN_WIDTH: signed two's-complement term.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer takes the result.
- `out_data`, out, OUT_WIDTH: signed group result.
- `out_overflow`, out, 1: result was clamped (always 0 when SATURATE="FALSE").

## Operation
- A beat is accepted when `in_valid & in_ready`. The output handshake completes when `out_valid & out_ready`.
- FSM has three states: IDLE, ACCUM, HOLD.
- **IDLE:** `in_ready = enable`.
  - On the first beat: `acc <= sext(in_data)` and `remain <= cfg_len - 1`, with wrap, so 0 gives 2^CNT_WIDTH - 1.
  - If `remain` would be 0, go to HOLD; otherwise go to ACCUM.
- **ACCUM:** `in_ready = enable`.
  - On each beat: `acc <= acc + sext(in_data)` and `remain <= remain - 1`.
  - The beat taken with `remain == 1` is the last; go to HOLD.
- **HOLD:** `out_valid = 1`, `in_ready = enable & out_ready`.
  - `out_data` and `out_overflow` are registered when entering HOLD and stay stable until the handshake completes.
  - On handshake with no input beat: go to IDLE.
  - On handshake with a simultaneous input beat: that beat is the first beat of the next group, processed exactly as in IDLE. This is the only way into ACCUM or HOLD directly from HOLD.
- `enable` does not gate the output side. HOLD drains on `out_ready` even when `enable = 0`.
- Arithmetic and width rules:
  - The sum is full-precision in ACC_WIDTH, and the parameter rule makes internal overflow impossible.
  - Result when SATURATE="TRUE": clamp `acc` to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and set `out_overflow` when clamped.
  - Result when SATURATE="FALSE": `acc[OUT_WIDTH-1:0]`.
- Reset (`reset = 0`), at any time including mid-group: state goes to IDLE; `acc`, `remain`, `out_data`, `out_overflow` and `out_valid` are cleared to 0. The partial group is discarded.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_overflow = 0`, `in_ready = 0` while reset is asserted. After release, `in_ready` follows `enable`.
- Latency: `out_valid` rises in the cycle after the last beat of a group is accepted.
- Throughput: with `out_ready` held at 1, a group of N terms occupies exactly N cycles and there are no bubbles between groups.
- Backpressure: while HOLD waits for `out_ready`, `in_ready = 0`. Data is never dropped or overwritten.
- `in_ready` and `out_valid` are functions of registered state plus `enable`/`out_ready` only. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `npu_acc_pkg` holds:
  - the FSM state enum (IDLE/ACCUM/HOLD);
  - the parameter-legality constants and checks.
- One sub-module: `signed_saturate`, a combinational ACC_WIDTH→OUT_WIDTH clamp that produces the overflow flag. It is reusable by other NPU output stages.

## Test plan
- **Basic group:** `cfg_len = 4`, beats 1, 2, 3, 4 on consecutive cycles with `out_ready = 1` → `out_data = 10`, `out_overflow = 0`, `out_valid` high exactly one cycle after the 4th beat.
- **Saturation:** `cfg_len = 3`, three beats of 30000 → `out_data = 32767`, `out_overflow = 1`. Then three beats of -30000 → `out_data = -32768`, `out_overflow = 1`. With SATURATE="FALSE", the first case gives `out_data = 90000 mod 2^16` (= 24464), `out_overflow = 0`.
- **Full-length group:** `cfg_len = 0` with 256 beats of -32768 → exactly 256 beats accepted and `acc = -8388608`, giving `out_data = -32768`, `out_overflow = 1`. The 257th beat starts a new group.
- **Backpressure and hand-over:** hold `out_ready = 0` for 5 cycles → `in_ready = 0`, `out_data` stable. Release with `in_valid = 1` → output taken and next group's first beat accepted in the same cycle. A two-group sequence [5, 6] and [7], with `cfg_len` 2 then 1, yields 11 then 7.
- **Enable stall:** `cfg_len = 3`, beats 10, 20, then `enable = 0` for 4 cycles with `in_valid = 1` → no beats accepted and `acc` unchanged. Beat 30 after `enable = 1` → `out_data = 60`.
- **Reset mid-group:** `cfg_len = 4`, two beats of 100, then a `reset` pulse → outputs 0 immediately. A new group of 4 beats of 1 → `out_data = 4`.
